// File: rtl/instruction_fetch.sv
// Instruction fetch: assembles 1..3 word instructions from memory at pc_f and
// holds them for the decoder until acked; a redirect aborts any fetch in flight.
module instruction_fetch #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   output logic [15:0] o_mem_addr,
   output logic        o_mem_rd,
   input  logic        i_mem_ready,
   input  logic [15:0] i_mem_rdata,
   output logic [15:0] o_ir1,
   output logic [15:0] o_ir2,
   output logic [15:0] o_ir3,
   output logic [1:0]  o_len,
   output logic [15:0] o_pc,
   output logic        o_valid,
   input  logic        i_ack,
   input  logic        i_redirect,
   input  logic [15:0] i_redirect_addr
);

   localparam logic [1:0] F1   = 2'd0;
   localparam logic [1:0] F2   = 2'd1;
   localparam logic [1:0] F3   = 2'd2;
   localparam logic [1:0] HOLD = 2'd3;

   logic [1:0]  state;
   logic [15:0] pc_f;
   logic        short_op;
   logic        imm16_hit;

   // Length decode looks at the word arriving this cycle, before it is registered.
   assign short_op  = (i_mem_rdata[15:12] == 4'hC) || (i_mem_rdata[15:12] == 4'hD);
   assign imm16_hit = (i_mem_rdata[15:12] == 4'h3) || (i_mem_rdata[11:8] == 4'h3);

   assign o_mem_rd   = (state == F1) || (state == F2) || (state == F3);
   assign o_mem_addr = pc_f;
   assign o_valid    = (state == HOLD);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= F1;
         pc_f  <= RESET_PC;
         o_ir1 <= '0;
         o_ir2 <= '0;
         o_ir3 <= '0;
         o_len <= '0;
         o_pc  <= '0;
      end else if (i_redirect) begin
         // Redirect wins over a coinciding ready or ack; partial words are dropped.
         pc_f  <= i_redirect_addr;
         state <= F1;
      end else begin
         case (state)
            F1: if (i_mem_ready) begin
               o_ir1 <= i_mem_rdata;
               o_pc  <= pc_f;
               pc_f  <= pc_f + 16'd1;
               if (short_op) begin
                  o_len <= 2'd1;
                  state <= HOLD;
               end else begin
                  state <= F2;
               end
            end
            F2: if (i_mem_ready) begin
               o_ir2 <= i_mem_rdata;
               pc_f  <= pc_f + 16'd1;
               if (imm16_hit) begin
                  state <= F3;
               end else begin
                  o_len <= 2'd2;
                  state <= HOLD;
               end
            end
            F3: if (i_mem_ready) begin
               o_ir3 <= i_mem_rdata;
               pc_f  <= pc_f + 16'd1;
               o_len <= 2'd3;
               state <= HOLD;
            end
            HOLD: if (i_ack) state <= F1;
            default: state <= F1;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus randomized fetches
// checked against an instruction-level model of length, latency and read order.
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic        mem_ready = 1'b0;
   logic [15:0] mem_rdata = '0;
   logic [15:0] ir1, ir2, ir3, pc;
   logic [1:0]  len;
   logic        valid;
   logic        ack = 1'b0;
   logic        redirect = 1'b0;
   logic [15:0] redirect_addr = '0;

   logic [15:0] mem [0:65535];
   int          wait_cfg = 0;
   int          wait_left = 0;
   logic [15:0] reads [$];
   logic [15:0] exp_reads [$];
   int          n_chk = 0;
   int          n_fail = 0;
   logic [15:0] mdl_ir2, mdl_ir3;

   instruction_fetch #(.RESET_PC(16'h0100)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .o_mem_addr(mem_addr), .o_mem_rd(mem_rd),
      .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata),
      .o_ir1(ir1), .o_ir2(ir2), .o_ir3(ir3), .o_len(len), .o_pc(pc), .o_valid(valid),
      .i_ack(ack), .i_redirect(redirect), .i_redirect_addr(redirect_addr)
   );

   always #5 clk = ~clk;

   // Memory: wait_cfg idle cycles before each ready; garbage data when not ready.
   always @(negedge clk) begin
      mem_ready = 1'b0;
      mem_rdata = 16'($urandom);
      if (!rst_n || !mem_rd) begin
         wait_left = wait_cfg;
      end else begin
         if (wait_left == 0) begin
            mem_ready = 1'b1;
            mem_rdata = mem[mem_addr];
            wait_left = wait_cfg;
         end else begin
            wait_left = wait_left - 1;
         end
         if (redirect) wait_left = wait_cfg;
      end
   end

   always @(posedge clk)
      if (rst_n && mem_rd && mem_ready && !redirect) reads.push_back(mem_addr);

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   function automatic int ref_len(logic [15:0] w1, logic [15:0] w2);
      if (w1[15:12] == 4'hC || w1[15:12] == 4'hD) return 1;
      if (w2[15:12] == 4'h3 || w2[11:8] == 4'h3) return 3;
      return 2;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_redirect(input logic [15:0] a);
      redirect = 1'b1;
      redirect_addr = a;
      step();
      redirect = 1'b0;
      reads.delete();
   endtask

   task automatic do_ack();
      ack = 1'b1;
      step();
      ack = 1'b0;
      reads.delete();
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!valid && cyc < 100) begin
         step();
         cyc++;
      end
      if (!valid) cyc = -1;
   endtask

   task automatic test_reset();
      int cyc;
      bit bad;
      repeat (3) @(posedge clk);
      #1;
      n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", valid); end
      n_chk++; if ({ir1, ir2, ir3, pc} !== 64'h0) begin n_fail++; $display("FAIL rst_regs: got %h expected 0", {ir1, ir2, ir3, pc}); end
      n_chk++; if (len !== 2'd0) begin n_fail++; $display("FAIL rst_len: got %0d expected 0", len); end
      n_chk++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0100) begin n_fail++; $display("FAIL rst_read: got rd=%b addr=%h expected rd=1 addr=0100", mem_rd, mem_addr); end
      rst_n = 1'b1;
      reads.delete();
      wait_valid(cyc);
      n_chk++; if (cyc !== 2) begin n_fail++; $display("FAIL rst_latency: got %0d expected 2", cyc); end
      n_chk++; if ({ir1, ir2, len, pc} !== {16'h1234, 16'h0012, 2'd2, 16'h0100}) begin n_fail++; $display("FAIL rst_instr: got ir1=%h ir2=%h len=%0d pc=%h expected 1234 0012 2 0100", ir1, ir2, len, pc); end
      exp_reads = '{16'h0100, 16'h0101};
      bad = (reads.size() != exp_reads.size());
      foreach (exp_reads[i]) if (i < reads.size() && reads[i] !== exp_reads[i]) bad = 1;
      n_chk++; if (bad) begin n_fail++; $display("FAIL rst_reads: got %p expected %p", reads, exp_reads); end
      step();
      n_chk++; if (valid !== 1'b1 || ir1 !== 16'h1234 || mem_rd !== 1'b0) begin n_fail++; $display("FAIL hold_stable: got valid=%b ir1=%h rd=%b expected 1 1234 0", valid, ir1, mem_rd); end
      do_ack();
      n_chk++; if (valid !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 16'h0102) begin n_fail++; $display("FAIL ack_next: got valid=%b rd=%b addr=%h expected 0 1 0102", valid, mem_rd, mem_addr); end
   endtask

   task automatic test_push_imm16();
      int cyc;
      do_redirect(16'h0000);
      wait_valid(cyc);
      n_chk++; if (cyc !== 1) begin n_fail++; $display("FAIL push_latency: got %0d expected 1", cyc); end
      n_chk++; if ({ir1, ir2, len, pc} !== {16'hD500, 16'h0012, 2'd1, 16'h0000}) begin n_fail++; $display("FAIL push_instr: got ir1=%h ir2=%h len=%0d pc=%h expected D500 0012 1 0000", ir1, ir2, len, pc); end
      n_chk++; if (reads.size() != 1 || reads[0] !== 16'h0000) begin n_fail++; $display("FAIL push_reads: got %p expected single read 0000", reads); end
      do_ack();
      wait_valid(cyc);
      n_chk++; if (cyc !== 3) begin n_fail++; $display("FAIL imm_latency: got %0d expected 3", cyc); end
      n_chk++; if ({ir1, ir2, ir3, len, pc} !== {16'h2000, 16'h3100, 16'hBEEF, 2'd3, 16'h0001}) begin n_fail++; $display("FAIL imm_instr: got %h %h %h len=%0d pc=%h expected 2000 3100 BEEF 3 0001", ir1, ir2, ir3, len, pc); end
      do_ack();
      do_redirect(16'h0010);
      wait_valid(cyc);
      n_chk++; if (cyc !== 3 || len !== 2'd3 || ir2 !== 16'h0300 || ir3 !== 16'h1111) begin n_fail++; $display("FAIL imm_low_nibble: got cyc=%0d len=%0d ir2=%h ir3=%h expected 3 3 0300 1111", cyc, len, ir2, ir3); end
      do_ack();
   endtask

   task automatic test_wait_states();
      bit bad;
      wait_cfg = 3;
      do_redirect(16'h0020);
      for (int k = 0; k < 8; k++) begin
         n_chk++;
         if (valid !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 16'(16'h0020 + k / 4)) begin
            n_fail++;
            $display("FAIL wait_hold_%0d: got valid=%b rd=%b addr=%h expected 0 1 %h", k, valid, mem_rd, mem_addr, 16'(16'h0020 + k / 4));
         end
         step();
      end
      n_chk++; if (valid !== 1'b1 || {ir1, ir2, len, pc} !== {16'h1000, 16'h0000, 2'd2, 16'h0020}) begin n_fail++; $display("FAIL wait_instr: got valid=%b ir1=%h ir2=%h len=%0d pc=%h expected 1 1000 0000 2 0020", valid, ir1, ir2, len, pc); end
      exp_reads = '{16'h0020, 16'h0021};
      bad = (reads.size() != exp_reads.size());
      foreach (exp_reads[i]) if (i < reads.size() && reads[i] !== exp_reads[i]) bad = 1;
      n_chk++; if (bad) begin n_fail++; $display("FAIL wait_reads: got %p expected %p", reads, exp_reads); end
      wait_cfg = 0;
      step();
      do_ack();
   endtask

   task automatic test_redirect_mid();
      int cyc;
      bit bad;
      do_redirect(16'h0030);
      step();
      // Now in the second-word read with ready about to be asserted.
      do_redirect(16'h4000);
      n_chk++; if (valid !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 16'h4000) begin n_fail++; $display("FAIL redir_mid: got valid=%b rd=%b addr=%h expected 0 1 4000", valid, mem_rd, mem_addr); end
      wait_valid(cyc);
      n_chk++; if (cyc !== 2) begin n_fail++; $display("FAIL redir_latency: got %0d expected 2", cyc); end
      n_chk++; if ({ir1, ir2, len, pc} !== {16'hA000, 16'h0000, 2'd2, 16'h4000}) begin n_fail++; $display("FAIL redir_instr: got ir1=%h ir2=%h len=%0d pc=%h expected A000 0000 2 4000", ir1, ir2, len, pc); end
      exp_reads = '{16'h4000, 16'h4001};
      bad = (reads.size() != exp_reads.size());
      foreach (exp_reads[i]) if (i < reads.size() && reads[i] !== exp_reads[i]) bad = 1;
      n_chk++; if (bad) begin n_fail++; $display("FAIL redir_reads: got %p expected %p", reads, exp_reads); end
   endtask

   task automatic test_redirect_ack_wrap();
      int cyc;
      bit bad;
      ack = 1'b1;
      do_redirect(16'hFFFE);
      ack = 1'b0;
      n_chk++; if (valid !== 1'b0 || mem_addr !== 16'hFFFE) begin n_fail++; $display("FAIL redir_ack: got valid=%b addr=%h expected 0 FFFE", valid, mem_addr); end
      wait_valid(cyc);
      n_chk++; if (cyc !== 3 || {ir1, ir2, ir3, len, pc} !== {16'h2000, 16'h3000, 16'h5555, 2'd3, 16'hFFFE}) begin n_fail++; $display("FAIL wrap_instr: got cyc=%0d %h %h %h len=%0d pc=%h expected 3 2000 3000 5555 3 FFFE", cyc, ir1, ir2, ir3, len, pc); end
      exp_reads = '{16'hFFFE, 16'hFFFF, 16'h0000};
      bad = (reads.size() != exp_reads.size());
      foreach (exp_reads[i]) if (i < reads.size() && reads[i] !== exp_reads[i]) bad = 1;
      n_chk++; if (bad) begin n_fail++; $display("FAIL wrap_reads: got %p expected %p", reads, exp_reads); end
      do_ack();
      n_chk++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0001) begin n_fail++; $display("FAIL wrap_next: got rd=%b addr=%h expected 1 0001", mem_rd, mem_addr); end
   endtask

   task automatic test_random();
      logic [15:0] a, w1, w2, w3, e2, e3;
      int w, n, cyc;
      bit bad;
      mdl_ir2 = 16'h3000;
      mdl_ir3 = 16'h5555;
      for (int it = 0; it < 40; it++) begin
         a  = 16'($urandom);
         w  = $urandom_range(0, 2);
         w1 = 16'($urandom);
         w2 = 16'($urandom);
         w3 = 16'($urandom);
         if ($urandom_range(0, 3) == 0) w1[15:12] = ($urandom_range(0, 1) == 0) ? 4'hC : 4'hD;
         case ($urandom_range(0, 2))
            0: w2[15:12] = 4'h3;
            1: w2[11:8] = 4'h3;
            default: ;
         endcase
         mem[a] = w1;
         mem[16'(a + 16'd1)] = w2;
         mem[16'(a + 16'd2)] = w3;
         wait_cfg = w;
         if (it > 0 && $urandom_range(0, 1) == 1) do_ack();
         do_redirect(a);
         n = ref_len(w1, w2);
         e2 = (n >= 2) ? w2 : mdl_ir2;
         e3 = (n == 3) ? w3 : mdl_ir3;
         wait_valid(cyc);
         n_chk++; if (cyc !== n * (w + 1)) begin n_fail++; $display("FAIL rnd_latency_%0d: got %0d expected %0d", it, cyc, n * (w + 1)); end
         n_chk++; if ({ir1, ir2, ir3, len, pc} !== {w1, e2, e3, 2'(n), a}) begin n_fail++; $display("FAIL rnd_instr_%0d: got %h %h %h len=%0d pc=%h expected %h %h %h %0d %h", it, ir1, ir2, ir3, len, pc, w1, e2, e3, n, a); end
         exp_reads.delete();
         for (int k = 0; k < n; k++) exp_reads.push_back(16'(a + 16'(k)));
         bad = (reads.size() != exp_reads.size());
         foreach (exp_reads[i]) if (i < reads.size() && reads[i] !== exp_reads[i]) bad = 1;
         n_chk++; if (bad) begin n_fail++; $display("FAIL rnd_reads_%0d: got %p expected %p", it, reads, exp_reads); end
         mdl_ir2 = e2;
         mdl_ir3 = e3;
      end
      wait_cfg = 0;
      step();
   endtask

   task automatic test_async_reset();
      int cyc;
      mem[16'h0100] = 16'h1234;
      mem[16'h0101] = 16'h0012;
      do_redirect(16'h0050);
      step();
      step();
      n_chk++; if (mem_addr !== 16'h0052 || mem_rd !== 1'b1) begin n_fail++; $display("FAIL arst_in_f3: got addr=%h rd=%b expected 0052 1", mem_addr, mem_rd); end
      #1 rst_n = 1'b0;
      #1;
      n_chk++; if (valid !== 1'b0 || {ir1, ir2, ir3, pc} !== 64'h0 || len !== 2'd0) begin n_fail++; $display("FAIL arst_regs: got valid=%b regs=%h len=%0d expected 0 0 0", valid, {ir1, ir2, ir3, pc}, len); end
      n_chk++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0100) begin n_fail++; $display("FAIL arst_read: got rd=%b addr=%h expected 1 0100", mem_rd, mem_addr); end
      step();
      rst_n = 1'b1;
      reads.delete();
      wait_valid(cyc);
      n_chk++; if (cyc !== 2 || ir1 !== 16'h1234 || pc !== 16'h0100) begin n_fail++; $display("FAIL arst_restart: got cyc=%0d ir1=%h pc=%h expected 2 1234 0100", cyc, ir1, pc); end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 16'(i * 37 + 16'h1111);
      mem[16'h0100] = 16'h1234; mem[16'h0101] = 16'h0012;
      mem[16'h0000] = 16'hD500; mem[16'h0001] = 16'h2000;
      mem[16'h0002] = 16'h3100; mem[16'h0003] = 16'hBEEF;
      mem[16'h0010] = 16'h2000; mem[16'h0011] = 16'h0300; mem[16'h0012] = 16'h1111;
      mem[16'h0020] = 16'h1000; mem[16'h0021] = 16'h0000;
      mem[16'h0030] = 16'h1000; mem[16'h0031] = 16'h2222;
      mem[16'h4000] = 16'hA000; mem[16'h4001] = 16'h0000;
      mem[16'h0050] = 16'h2000; mem[16'h0051] = 16'h3000; mem[16'h0052] = 16'h7777;
      test_reset();
      test_push_imm16();
      test_wait_states();
      test_redirect_mid();
      mem[16'hFFFE] = 16'h2000; mem[16'hFFFF] = 16'h3000; mem[16'h0000] = 16'h5555;
      test_redirect_ack_wrap();
      test_random();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
